// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares the instruction memory's single combinational read port between fetch (IF) and debug (DBG).
// Build option: define IMEM_ARB_RR_EN for round-robin arbitration; otherwise IF has priority and DBG ages up to MAX_WAIT.
module imem_fetch_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    input  logic        dbg_req_valid,
    output logic        dbg_req_ready,
    input  logic [31:0] dbg_req_addr,
    output logic        dbg_resp_valid,
    input  logic        dbg_resp_ready,
    output logic [31:0] dbg_resp_data,
    output logic        resp_misalign,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout
);
    // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1, a response
    // where resp_valid & resp_ready are both 1. Ready may depend on valid; valid must not depend on ready.

    typedef enum logic { IDLE = 1'b0, PEND = 1'b1 } state_t;
    typedef enum logic { OWN_IF = 1'b0, OWN_DBG = 1'b1 } owner_t;

    state_t      state;
    owner_t      owner;
    logic        owner_done;
    logic        can_accept;
    logic        dbg_wins;
    logic        grant_if;
    logic        grant_dbg;
    logic        accept;
    logic [31:0] accept_addr;

    assign owner_done = (owner == OWN_IF) ? (if_resp_valid & if_resp_ready)
                                          : (dbg_resp_valid & dbg_resp_ready);
    assign can_accept = (state == IDLE) | owner_done;

`ifdef IMEM_ARB_RR_EN
    logic rr_ptr;
    assign dbg_wins = rr_ptr;
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;
    assign dbg_wins = (wait_cnt == WW'(MAX_WAIT));
`endif

    assign grant_dbg     = dbg_req_valid & (~if_req_valid | dbg_wins);
    assign grant_if      = if_req_valid & ~grant_dbg;
    assign if_req_ready  = grant_if & can_accept;
    assign dbg_req_ready = grant_dbg & can_accept;
    assign accept        = if_req_ready | dbg_req_ready;
    assign accept_addr   = grant_dbg ? dbg_req_addr : if_req_addr;
    assign mem_addr      = accept ? accept_addr : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= OWN_IF;
            if_resp_valid  <= 1'b0;
            dbg_resp_valid <= 1'b0;
            if_resp_data   <= 32'h0;
            dbg_resp_data  <= 32'h0;
            resp_misalign  <= 1'b0;
        end else begin
            case (state)
                IDLE, PEND: begin
                    if (accept) begin
                        // A new accept may overlap the consuming handshake of the previous response.
                        state          <= PEND;
                        owner          <= grant_dbg ? OWN_DBG : OWN_IF;
                        if_resp_valid  <= ~grant_dbg;
                        dbg_resp_valid <= grant_dbg;
                        resp_misalign  <= |accept_addr[1:0];
                        if (grant_dbg) dbg_resp_data <= mem_dout;
                        else           if_resp_data  <= mem_dout;
                    end else if (owner_done) begin
                        state          <= IDLE;
                        if_resp_valid  <= 1'b0;
                        dbg_resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      rr_ptr <= 1'b0;
        else if (accept) rr_ptr <= ~grant_dbg;
    end
`else
    // Only cycles where an accept was possible and IF took it count toward DBG's aging limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dbg_req_valid || dbg_req_ready) begin
            wait_cnt <= '0;
        end else if (can_accept && (wait_cnt != WW'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: directed and randomized checks of imem_fetch_arbiter against a cycle-level reference model.
// Honors IMEM_ARB_RR_EN the same way as the design.
module tb_imem_fetch_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [31:0] if_req_addr, if_resp_data;
    logic        dbg_req_valid, dbg_req_ready, dbg_resp_valid, dbg_resp_ready;
    logic [31:0] dbg_req_addr, dbg_resp_data;
    logic        resp_misalign;
    logic [31:0] mem_addr, mem_dout;

    logic [31:0] mem [0:1023];
    assign mem_dout = mem[mem_addr[11:2]];

    always #5 clk = ~clk;

    imem_fetch_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
        .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready), .dbg_resp_data(dbg_resp_data),
        .resp_misalign(resp_misalign), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: one outstanding response at most, owned by one port.
    bit          m_pend;
    bit          m_owner_dbg;
    int          m_wait;
    bit          m_rr;
    logic [31:0] m_if_data, m_dbg_data;
    bit          m_mis;
    bit          last_acc_if, last_acc_dbg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[(a >> 2) % 1024];
    endfunction

    task automatic model_reset();
        m_pend = 0; m_owner_dbg = 0; m_wait = 0; m_rr = 0;
        m_if_data = 32'h0; m_dbg_data = 32'h0; m_mis = 0;
    endtask

    task automatic check_resp(input string tag);
        chk({tag, " if_resp_valid"},  32'(if_resp_valid),  32'(m_pend && !m_owner_dbg));
        chk({tag, " dbg_resp_valid"}, 32'(dbg_resp_valid), 32'(m_pend && m_owner_dbg));
        chk({tag, " if_resp_data"},   if_resp_data,  m_if_data);
        chk({tag, " dbg_resp_data"},  dbg_resp_data, m_dbg_data);
        chk({tag, " resp_misalign"},  32'(resp_misalign), 32'(m_mis));
    endtask

    // One clock cycle: inputs are already driven; check combinational outputs, clock, check registered outputs.
    task automatic step(input string tag);
        bit          can_acc, any_v, dbg_first, g_dbg, acc;
        logic [31:0] a;
        #1;
        can_acc = !m_pend || (m_owner_dbg ? dbg_resp_ready : if_resp_ready);
        any_v   = if_req_valid || dbg_req_valid;
`ifdef IMEM_ARB_RR_EN
        dbg_first = m_rr;
`else
        dbg_first = (m_wait == MAX_WAIT);
`endif
        g_dbg = dbg_req_valid && (!if_req_valid || dbg_first);
        acc   = can_acc && any_v;
        a     = g_dbg ? dbg_req_addr : if_req_addr;
        chk({tag, " if_req_ready"},  32'(if_req_ready),  32'(acc && !g_dbg));
        chk({tag, " dbg_req_ready"}, 32'(dbg_req_ready), 32'(acc && g_dbg));
        chk({tag, " mem_addr"},      mem_addr, acc ? a : 32'h0);
        last_acc_if  = acc && !g_dbg;
        last_acc_dbg = acc && g_dbg;
        @(posedge clk);
        if (!dbg_req_valid || (acc && g_dbg)) m_wait = 0;
        else if (can_acc && m_wait < MAX_WAIT) m_wait++;
        if (acc) begin
            m_pend = 1; m_owner_dbg = g_dbg; m_rr = !g_dbg;
            if (g_dbg) m_dbg_data = word_at(a);
            else       m_if_data  = word_at(a);
            m_mis = (a % 4) != 0;
        end else if (m_pend && can_acc) begin
            m_pend = 0;
        end
        #1;
        check_resp(tag);
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = 32'h0; if_resp_ready = 1;
        dbg_req_valid = 0; dbg_req_addr = 32'h0; dbg_resp_ready = 1;
    endtask

    initial begin
        int          n_resp;
        int          dbg_cycle;
        logic [31:0] held;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[1]    = 32'h00500093;
        mem[1023] = 32'hDEADBEEF;

        // Reset state
        idle_inputs();
        reset = 0;
        model_reset();
        #1;
        check_resp("reset");
        chk("reset mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        step("idle");

        // Single IF fetch, then back-to-back 4, 8, C
        if_req_valid = 1; if_req_addr = 32'h4;
        step("if4");
        chk("if4 data", if_resp_data, 32'h00500093);
        chk("if4 misalign", 32'(resp_misalign), 32'h0);
        n_resp = 0;
        for (int i = 0; i < 3; i++) begin
            if_req_addr = 32'h4 + 32'(4 * i);
            step("b2b");
            if (if_resp_valid) n_resp++;
        end
        chk("b2b responses", 32'(n_resp), 32'd3);

        // IF response stalled for 3 cycles with both requests waiting
        if_resp_ready = 0; if_req_addr = 32'h10; dbg_req_valid = 1; dbg_req_addr = 32'h40;
        held = if_resp_data;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall data held", if_resp_data, held);
        end
        if_resp_ready = 1;
        step("unstall");
        chk("unstall IF accept", 32'(last_acc_if), 32'h1);

        // Reset while an IF response is pending
        dbg_req_valid = 0; if_req_valid = 0; if_resp_ready = 0;
        step("pre-reset");
        chk("pre-reset pending", 32'(if_resp_valid), 32'h1);
        reset = 0;
        model_reset();
        #1;
        check_resp("async reset");
        @(posedge clk);
        #1 reset = 1;
        if_resp_ready = 1;
        step("post-reset");

        // IF stream with DBG waiting continuously
        if_req_valid = 1; if_req_addr = 32'h100; dbg_req_valid = 1; dbg_req_addr = 32'h20;
        dbg_cycle = 0;
        for (int i = 1; i <= 7; i++) begin
            step("aging");
            if (last_acc_dbg && dbg_cycle == 0) begin
                dbg_cycle = i;
                dbg_req_valid = 0;
            end
            if (last_acc_if) if_req_addr += 32'h4;
        end
`ifdef IMEM_ARB_RR_EN
        chk("dbg grant cycle", 32'(dbg_cycle), 32'd2);
`else
        chk("dbg grant cycle", 32'(dbg_cycle), 32'd5);
`endif
        chk("IF resumes", 32'(last_acc_if), 32'h1);

        // DBG misaligned and wrapped addresses
        if_req_valid = 0;
        step("drain");
        dbg_req_valid = 1; dbg_req_addr = 32'h1006;
        step("dbg1006");
        chk("dbg1006 data", dbg_resp_data, 32'h00500093);
        chk("dbg1006 misalign", 32'(resp_misalign), 32'h1);
        dbg_req_addr = 32'hFFC;
        step("dbgFFC");
        chk("dbgFFC data", dbg_resp_data, 32'hDEADBEEF);
        chk("dbgFFC misalign", 32'(resp_misalign), 32'h0);

        // Both valid continuously: RR alternates; fixed priority lets DBG in on the 5th cycle
        dbg_req_valid = 0;
        step("drain2");
        if_req_valid = 1; if_req_addr = 32'h8; dbg_req_valid = 1; dbg_req_addr = 32'hC;
        for (int i = 0; i < 6; i++) begin
            step("both");
`ifdef IMEM_ARB_RR_EN
            chk("rr order", 32'(last_acc_dbg), 32'(i % 2));
`else
            chk("prio order", 32'(last_acc_dbg), 32'(i == 4));
`endif
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if_req_valid   = ($urandom_range(0, 3) != 0);
            dbg_req_valid  = ($urandom_range(0, 1) != 0);
            if_req_addr    = $urandom;
            dbg_req_addr   = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            if_resp_ready  = ($urandom_range(0, 3) != 0);
            dbg_resp_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
